// File: rtl/multicycle_control_unit.sv
// Control FSM for a multicycle MIPS-like datapath: sequences fetch, decode,
// execute, memory and write-back, and decodes per-state datapath controls.
module multicycle_control_unit (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       mRD,
  output logic       mWR,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       DBDataSrc,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOp,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    s_if     = 3'b000,
    s_id     = 3'b001,
    s_exe_ls = 3'b010,
    s_mem    = 3'b011,
    s_wb_ld  = 3'b100,
    s_exe_br = 3'b101,
    s_exe_al = 3'b110,
    s_wb_al  = 3'b111
  } state_t;

  localparam logic [5:0] op_add   = 6'b000000;
  localparam logic [5:0] op_sub   = 6'b000001;
  localparam logic [5:0] op_addiu = 6'b000010;
  localparam logic [5:0] op_and   = 6'b010000;
  localparam logic [5:0] op_andi  = 6'b010001;
  localparam logic [5:0] op_ori   = 6'b010010;
  localparam logic [5:0] op_slt   = 6'b100110;
  localparam logic [5:0] op_slti  = 6'b100111;
  localparam logic [5:0] op_sw    = 6'b110000;
  localparam logic [5:0] op_lw    = 6'b110001;
  localparam logic [5:0] op_beq   = 6'b110100;
  localparam logic [5:0] op_bne   = 6'b110101;
  localparam logic [5:0] op_j     = 6'b111000;
  localparam logic [5:0] op_jr    = 6'b111001;
  localparam logic [5:0] op_jal   = 6'b111010;
  localparam logic [5:0] op_halt  = 6'b111111;

  localparam logic [2:0] alu_add = 3'b000;
  localparam logic [2:0] alu_sub = 3'b001;
  localparam logic [2:0] alu_and = 3'b100;
  localparam logic [2:0] alu_or  = 3'b101;
  localparam logic [2:0] alu_slt = 3'b110;

  state_t cur_state;
  state_t nxt_state;

  // Opcode classification shared by next-state and output decode
  logic       is_rtype;
  logic       is_imm;
  logic       is_ls;
  logic       is_branch;
  logic       imm_sext;
  logic [2:0] alu_fn;

  always_comb begin
    is_rtype  = 1'b0;
    is_imm    = 1'b0;
    is_ls     = 1'b0;
    is_branch = 1'b0;
    imm_sext  = 1'b0;
    alu_fn    = alu_add;
    case (opcode)
      op_add:   begin is_rtype = 1'b1; alu_fn = alu_add; end
      op_sub:   begin is_rtype = 1'b1; alu_fn = alu_sub; end
      op_and:   begin is_rtype = 1'b1; alu_fn = alu_and; end
      op_slt:   begin is_rtype = 1'b1; alu_fn = alu_slt; end
      op_addiu: begin is_imm = 1'b1; imm_sext = 1'b1; alu_fn = alu_add; end
      op_andi:  begin is_imm = 1'b1; alu_fn = alu_and; end
      op_ori:   begin is_imm = 1'b1; alu_fn = alu_or;  end
      op_slti:  begin is_imm = 1'b1; imm_sext = 1'b1; alu_fn = alu_slt; end
      op_sw, op_lw:   is_ls = 1'b1;
      op_beq, op_bne: is_branch = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) cur_state <= s_if;
    else        cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = s_if;
    case (cur_state)
      s_if: nxt_state = s_id;
      s_id: begin
        if (opcode == op_halt)         nxt_state = s_id;
        else if (is_branch)            nxt_state = s_exe_br;
        else if (is_ls)                nxt_state = s_exe_ls;
        else if (is_rtype || is_imm)   nxt_state = s_exe_al;
        else                           nxt_state = s_if;
      end
      s_exe_ls: nxt_state = s_mem;
      s_mem:    nxt_state = (opcode == op_lw) ? s_wb_ld : s_if;
      s_wb_ld:  nxt_state = s_if;
      s_exe_br: nxt_state = s_if;
      s_exe_al: nxt_state = s_wb_al;
      s_wb_al:  nxt_state = s_if;
      default:  nxt_state = s_if;
    endcase
  end

  // Output decode; anything not raised in a state stays 0
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    RegWre    = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    PCSrc     = 2'b00;
    ALUOp     = 3'b000;
    case (cur_state)
      s_if: begin
        IRWre    = 1'b1;
        InsMemRW = 1'b1;
      end
      s_id: begin
        // Jumps and undefined opcodes retire here; multi-cycle ones and halt do not
        case (opcode)
          op_j: begin
            PCWre = 1'b1;
            PCSrc = 2'b11;
          end
          op_jr: begin
            PCWre = 1'b1;
            PCSrc = 2'b10;
          end
          op_jal: begin
            PCWre     = 1'b1;
            PCSrc     = 2'b11;
            RegWre    = 1'b1;
            RegDst    = 2'b00;
            WrRegDSrc = 1'b0;
          end
          op_halt: ;
          default: begin
            if (!(is_rtype || is_imm || is_ls || is_branch)) begin
              PCWre = 1'b1;
              PCSrc = 2'b00;
            end
          end
        endcase
      end
      s_exe_br: begin
        PCWre   = 1'b1;
        ALUOp   = alu_sub;
        ALUSrcB = 1'b0;
        ExtSel  = 1'b1;
        if (((opcode == op_beq) && zero) || ((opcode == op_bne) && !zero))
          PCSrc = 2'b01;
      end
      s_exe_ls: begin
        ALUOp   = alu_add;
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
      end
      s_mem: begin
        ALUOp   = alu_add;
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
        mRD     = (opcode == op_lw);
        mWR     = (opcode == op_sw);
        PCWre   = (opcode != op_lw);
      end
      s_wb_ld: begin
        PCWre     = 1'b1;
        RegWre    = 1'b1;
        RegDst    = 2'b01;
        WrRegDSrc = 1'b1;
        DBDataSrc = 1'b1;
      end
      s_exe_al: begin
        ALUOp   = alu_fn;
        ALUSrcB = is_imm;
        ExtSel  = is_imm && imm_sext;
      end
      s_wb_al: begin
        ALUOp     = alu_fn;
        ALUSrcB   = is_imm;
        ExtSel    = is_imm && imm_sext;
        PCWre     = 1'b1;
        RegWre    = 1'b1;
        RegDst    = is_rtype ? 2'b10 : 2'b01;
        WrRegDSrc = 1'b1;
        DBDataSrc = 1'b0;
      end
      default: ;
    endcase

    // Hold every write strobe and select low while reset is asserted
    if (!Reset) begin
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      InsMemRW  = 1'b0;
      mRD       = 1'b0;
      mWR       = 1'b0;
      RegWre    = 1'b0;
      RegDst    = 2'b00;
      WrRegDSrc = 1'b0;
      DBDataSrc = 1'b0;
      ALUSrcB   = 1'b0;
      ExtSel    = 1'b0;
      PCSrc     = 2'b00;
      ALUOp     = 3'b000;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction cycle model feeding an
// expected queue, checked every cycle, plus directed literal checks.
module tb_multicycle_control_unit;

  logic       CLK;
  logic       Reset;
  logic [5:0] opcode;
  logic       zero;
  logic       PCWre, IRWre, InsMemRW, mRD, mWR, RegWre;
  logic [1:0] RegDst;
  logic       WrRegDSrc, DBDataSrc, ALUSrcB, ExtSel;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp;
  logic [2:0] state;

  multicycle_control_unit dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .mRD(mRD), .mWR(mWR),
    .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
    .DBDataSrc(DBDataSrc), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel),
    .PCSrc(PCSrc), .ALUOp(ALUOp), .state(state)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int tests = 0;
  int fails = 0;
  logic check_en = 1'b0;

  // expected record: {branch kind[21:20], state[19:17], outputs[16:0]}
  logic [21:0] exp_q[$];
  logic [2:0]  seen[$];
  logic [2:0]  last_state;
  logic [16:0] last_outs;

  wire [16:0] act_outs = {PCWre, IRWre, InsMemRW, mRD, mWR, RegWre, RegDst,
                          WrRegDSrc, DBDataSrc, ALUSrcB, ExtSel, PCSrc, ALUOp};

  function automatic logic [16:0] pk(
    input logic pcwre, input logic irwre, input logic insm, input logic mrd,
    input logic mwr, input logic regwre, input logic [1:0] regdst,
    input logic wrsrc, input logic dbsrc, input logic srcb, input logic ext,
    input logic [1:0] pcsrc, input logic [2:0] aluop);
    return {pcwre, irwre, insm, mrd, mwr, regwre, regdst, wrsrc, dbsrc,
            srcb, ext, pcsrc, aluop};
  endfunction

  function automatic logic [21:0] rec(input logic [1:0] br, input logic [2:0] st,
                                      input logic [16:0] o);
    return {br, st, o};
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] op);
    case (op)
      6'd1:         return 3'b001;
      6'd16, 6'd17: return 3'b100;
      6'd18:        return 3'b101;
      6'd38, 6'd39: return 3'b110;
      default:      return 3'b000;
    endcase
  endfunction

  // Behavioural model: push the expected cycle-by-cycle trace of one instruction
  function automatic int build(input logic [5:0] op);
    logic rtype, imm, ext;
    logic [16:0] z;
    logic [2:0] a;
    z = '0;
    rtype = (op == 6'd0) || (op == 6'd1) || (op == 6'd16) || (op == 6'd38);
    imm   = (op == 6'd2) || (op == 6'd17) || (op == 6'd18) || (op == 6'd39);
    ext   = (op == 6'd2) || (op == 6'd39);
    a     = alu_of(op);
    exp_q.push_back(rec(2'd0, 3'd0, pk(0,1,1,0,0,0,2'b00,0,0,0,0,2'b00,3'b000)));
    if (rtype || imm) begin
      exp_q.push_back(rec(2'd0, 3'd1, z));
      exp_q.push_back(rec(2'd0, 3'd6, pk(0,0,0,0,0,0,2'b00,0,0,imm,ext,2'b00,a)));
      exp_q.push_back(rec(2'd0, 3'd7, pk(1,0,0,0,0,1, rtype ? 2'b10 : 2'b01,
                                         1,0,imm,ext,2'b00,a)));
      return 4;
    end
    if (op == 6'd48 || op == 6'd49) begin
      exp_q.push_back(rec(2'd0, 3'd1, z));
      exp_q.push_back(rec(2'd0, 3'd2, pk(0,0,0,0,0,0,2'b00,0,0,1,1,2'b00,3'b000)));
      exp_q.push_back(rec(2'd0, 3'd3, pk(op == 6'd48,0,0,op == 6'd49,op == 6'd48,0,
                                         2'b00,0,0,1,1,2'b00,3'b000)));
      if (op == 6'd49) begin
        exp_q.push_back(rec(2'd0, 3'd4, pk(1,0,0,0,0,1,2'b01,1,1,0,0,2'b00,3'b000)));
        return 5;
      end
      return 4;
    end
    if (op == 6'd52 || op == 6'd53) begin
      exp_q.push_back(rec(2'd0, 3'd1, z));
      exp_q.push_back(rec(op == 6'd52 ? 2'd1 : 2'd2, 3'd5,
                          pk(1,0,0,0,0,0,2'b00,0,0,0,1,2'b00,3'b001)));
      return 3;
    end
    if (op == 6'd63) begin
      for (int i = 0; i < 10; i++) exp_q.push_back(rec(2'd0, 3'd1, z));
      return 11;
    end
    case (op)
      6'd56:   exp_q.push_back(rec(2'd0, 3'd1, pk(1,0,0,0,0,0,2'b00,0,0,0,0,2'b11,3'b000)));
      6'd57:   exp_q.push_back(rec(2'd0, 3'd1, pk(1,0,0,0,0,0,2'b00,0,0,0,0,2'b10,3'b000)));
      6'd58:   exp_q.push_back(rec(2'd0, 3'd1, pk(1,0,0,0,0,1,2'b00,0,0,0,0,2'b11,3'b000)));
      default: exp_q.push_back(rec(2'd0, 3'd1, pk(1,0,0,0,0,0,2'b00,0,0,0,0,2'b00,3'b000)));
    endcase
    return 2;
  endfunction

  // scoreboard compare: every cycle, away from the active edge
  always @(negedge CLK) begin
    logic [21:0] e;
    logic [16:0] eo;
    if (!Reset) begin
      tests++;
      if (act_outs !== 17'd0) begin
        fails++;
        $display("FAIL reset_outs: got %h expected 00000 (state %0d)", act_outs, state);
      end
    end
    if (check_en) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL queue_underflow: got cycle in state %0d expected none", state);
      end else begin
        e  = exp_q.pop_front();
        eo = e[16:0];
        if (e[21:20] == 2'd1) eo[4:3] = zero ? 2'b01 : 2'b00;
        if (e[21:20] == 2'd2) eo[4:3] = zero ? 2'b00 : 2'b01;
        if (state !== e[19:17]) begin
          fails++;
          $display("FAIL state: got %0d expected %0d (opcode %b)", state, e[19:17], opcode);
        end
        tests++;
        if (act_outs !== eo) begin
          fails++;
          $display("FAIL outs: got %b expected %b (state %0d opcode %b zero %b)",
                   act_outs, eo, state, opcode, zero);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: called at posedge+1 with the DUT in sIF
  task automatic run_instr(input logic [5:0] op, input int zmode, input bit drop_last);
    int n;
    opcode = op;
    n = build(op);
    if (drop_last) begin
      void'(exp_q.pop_back());
      n--;
    end
    seen.delete();
    for (int i = 0; i < n; i++) begin
      zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      seen.push_back(state);
      last_state = state;
      last_outs  = act_outs;
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic logic [14:0] seen_pack();
    logic [14:0] v;
    v = '0;
    foreach (seen[i]) if (i < 5) v[14 - 3*i -: 3] = seen[i];
    return v;
  endfunction

  initial begin
    logic [5:0] op;
    Reset  = 1'b0;
    opcode = 6'd0;
    zero   = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_state", 32'(state), 32'd0);
    Reset    = 1'b1;
    check_en = 1'b1;

    // add: 000,001,110,111 then back to 000
    run_instr(6'd0, -1, 1'b0);
    chk("add_states", 32'(seen_pack()), 32'({3'd0, 3'd1, 3'd6, 3'd7, 3'd0}));
    chk("add_wb_regdst", 32'({last_outs[16], last_outs[11], last_outs[10:9]}), 32'b1110);
    chk("add_back_if", 32'(state), 32'd0);

    // lw: 000,001,010,011,100
    run_instr(6'd49, -1, 1'b0);
    chk("lw_states", 32'(seen_pack()), 32'({3'd0, 3'd1, 3'd2, 3'd3, 3'd4}));
    chk("lw_wb", 32'({last_outs[11], last_outs[10:9], last_outs[7]}), 32'b1011);

    // beq/bne with both zero values
    run_instr(6'd52, 1, 1'b0);
    chk("beq_z1", 32'({last_state, last_outs[16], last_outs[4:3]}), 32'b101101);
    run_instr(6'd52, 0, 1'b0);
    chk("beq_z0", 32'({last_state, last_outs[16], last_outs[4:3]}), 32'b101100);
    run_instr(6'd53, 1, 1'b0);
    chk("bne_z1", 32'({last_state, last_outs[16], last_outs[4:3]}), 32'b101100);
    run_instr(6'd53, 0, 1'b0);
    chk("bne_z0", 32'({last_state, last_outs[16], last_outs[4:3]}), 32'b101101);

    // jal retires in decode
    run_instr(6'd58, -1, 1'b0);
    chk("jal_id", 32'({last_state, last_outs[16], last_outs[11], last_outs[10:9],
                       last_outs[8], last_outs[4:3]}), 32'b001_1_1_00_0_11);
    chk("jal_next", 32'(state), 32'd0);

    // halt holds in decode until reset
    run_instr(6'd63, -1, 1'b0);
    check_en = 1'b0;
    chk("halt_hold_state", 32'(state), 32'd1);
    chk("halt_pcwre", 32'(PCWre), 32'd0);
    Reset = 1'b0;
    @(posedge CLK);
    #1;
    chk("halt_reset_state", 32'(state), 32'd0);
    Reset    = 1'b1;
    check_en = 1'b1;

    // sw interrupted by reset in sMEM
    run_instr(6'd48, -1, 1'b1);
    check_en = 1'b0;
    chk("sw_mem_state", 32'(state), 32'd3);
    chk("sw_mem_mwr", 32'(mWR), 32'd1);
    Reset = 1'b0;
    #1;
    chk("sw_reset_mwr", 32'({mWR, PCWre}), 32'd0);
    @(posedge CLK);
    #1;
    chk("sw_reset_state", 32'(state), 32'd0);
    Reset    = 1'b1;
    check_en = 1'b1;

    // randomized instruction stream, including undefined opcodes
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 2))
        0: op = 6'($urandom_range(0, 63));
        default: begin
          case ($urandom_range(0, 14))
            0: op = 6'd0;   1: op = 6'd1;   2: op = 6'd2;   3: op = 6'd16;
            4: op = 6'd17;  5: op = 6'd18;  6: op = 6'd38;  7: op = 6'd39;
            8: op = 6'd48;  9: op = 6'd49;  10: op = 6'd52; 11: op = 6'd53;
            12: op = 6'd56; 13: op = 6'd57; default: op = 6'd58;
          endcase
        end
      endcase
      if (op == 6'd63) op = 6'd0;
      run_instr(op, -1, 1'b0);
    end

    check_en = 1'b0;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
